// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - TLB miss refill FSM: PTW request, victim choice, TLB write, PLRU touch.
// Optional build macro TLB_REFILL_INVALID_FIRST_EN: prefer the lowest invalid slot as victim.
module tlb_refill_ctrl #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int DATA_W  = 64,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [VPN_W-1:0]  miss_vpn_i,
  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [VPN_W-1:0]  ptw_req_vpn_o,
  input  logic              ptw_resp_valid_i,
  input  logic              ptw_resp_error_i,
  input  logic [DATA_W-1:0] ptw_resp_data_i,
  input  logic [ENTRIES-1:0] valid_vec_i,
  input  logic [IDX_W-1:0]  plru_idx_i,
  input  logic              flush_i,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  wr_idx_o,
  output logic [VPN_W-1:0]  wr_vpn_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              touch_o,
  output logic [IDX_W-1:0]  touch_idx_o,
  output logic              done_o,
  output logic              done_error_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_e;

  state_e             state_q, state_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   victim_q, victim_d;
  logic               drop_q, drop_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   victim_sel;

`ifdef TLB_REFILL_INVALID_FIRST_EN
  // Scan downwards so the lowest-index free slot wins.
  always_comb begin
    victim_sel = plru_idx_i;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec_i[i]) victim_sel = IDX_W'(i);
    end
  end
`else
  logic unused_valid;
  assign unused_valid = ^valid_vec_i;
  assign victim_sel   = plru_idx_i;
`endif

  always_comb begin
    state_d  = state_q;
    vpn_d    = vpn_q;
    data_d   = data_q;
    victim_d = victim_q;
    drop_d   = drop_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (miss_valid_i && !flush_i) begin
          vpn_d   = miss_vpn_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) drop_d = 1'b1;
        if (ptw_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ptw_resp_valid_i) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          // A flushed refill still has to swallow its response.
          if (!drop_q && !flush_i) begin
            if (ptw_resp_error_i) begin
              err_d = 1'b1;
            end else begin
              data_d   = ptw_resp_data_i;
              victim_d = victim_sel;
              state_d  = S_WRITE;
            end
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      data_q   <= '0;
      victim_q <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      data_q   <= data_d;
      victim_q <= victim_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  // rstn_i gating keeps every output low while reset is held.
  assign miss_ready_o    = rstn_i && (state_q == S_IDLE) && !flush_i;
  assign ptw_req_valid_o = (state_q == S_REQ);
  assign ptw_req_vpn_o   = vpn_q;
  assign wr_en_o         = (state_q == S_WRITE) && !flush_i;
  assign touch_o         = wr_en_o;
  assign wr_idx_o        = victim_q;
  assign touch_idx_o     = victim_q;
  assign wr_vpn_o        = vpn_q;
  assign wr_data_o       = data_q;
  assign done_o          = wr_en_o || err_q;
  assign done_error_o    = err_q;

endmodule
